vend_controller: RTL
====================

// Module: vend_controller
// PURPOSE
//   Sequencing FSM around the coin-credit datapath of the vending machine.
//   Accumulates coin credit, issues a dispense request to the product mechanism
//   (req/ack handshake) once PRICE is reached, and returns change or refunds as
//   serial nickel pulses. Sits between coin acceptor inputs and the dispenser.
// PARAMETERS
//   PRICE           100   product price in cents; multiple of 5, 5..215
//   CREDIT_W        8     credit register width; must hold PRICE-5+80
//   TIMEOUT_CYCLES  1000  idle cycles in COLLECT before auto-refund (TIMEOUT_EN only)
// PORTS
//   clk            in   1         system clock, all state on posedge
//   reset_n        in   1         asynchronous active-low reset
//   nickel         in   1         5c coin present this cycle (sync, 1-cycle pulse)
//   dime           in   1         10c coin present this cycle
//   quarter        in   1         25c coin present this cycle; any mix may coincide
//   cancel         in   1         customer refund request, sampled per cycle
//   vend_ack       in   1         dispenser accepted the request
//   vend_req       out  1         dispense request, held until vend_ack
//   change_nickel  out  1         one pulse = one 5c coin returned
//   coin_reject    out  1         coin(s) arrived while busy; returned to customer
//   busy           out  1         state is VEND or REFUND
//   credit         out  CREDIT_W  current credit in cents
// BEHAVIOUR
//   Reset: state=IDLE; credit, vend_req, change_nickel, coin_reject, busy = 0.
//   Reset mid-operation: credit discarded, vend_req drops asynchronously.
//   All outputs decode from registered state only; no input-to-output comb path.
//   tally = 25*quarter + 10*dime + 5*nickel (0..40), computed combinationally.
//   States:
//   IDLE    credit==0. tally>0 -> COLLECT, credit<=tally. cancel ignored.
//   COLLECT credit<=credit+tally every cycle (visible next cycle).
//           cancel -> REFUND (includes same-cycle tally) ; cancel has priority.
//           else registered credit>=PRICE -> VEND (same-cycle tally still added).
//   VEND    vend_req=1. Coins not credited: coin_reject=1 next cycle.
//           vend_ack=1 -> credit<=credit-PRICE; remainder>0 -> REFUND else IDLE.
//           cancel ignored; waits for vend_ack indefinitely.
//   REFUND  change_nickel=1 each cycle, credit-=5 per cycle; at credit==5 the
//           final pulse is issued and state -> IDLE. Refund of N cents = N/5
//           consecutive pulses. Coins rejected as in VEND.
//   vend_ack outside VEND ignored. coin_reject is a registered 1-cycle pulse.
//   Max credit PRICE-5+40+40 (entry of VEND plus decision-cycle coin); no wrap.
// CONFIGURATION
//   VEND_TIMEOUT_EN defined: counter of consecutive coin-free COLLECT cycles;
//     reaching TIMEOUT_CYCLES acts as cancel (-> REFUND). Any coin clears it;
//     counter cleared on leaving COLLECT.
//   VEND_TIMEOUT_EN undefined: COLLECT holds credit indefinitely; no counter.
// TESTING
//   4 quarters on 4 cycles, vend_ack 2 cycles after vend_req -> vend_req 1
//     cycle after credit=100, single vend, credit 0, IDLE, no change_nickel.
//   quarter x3, then quarter+dime same cycle -> credit 110, vend, after ack
//     2 change_nickel pulses back-to-back, credit 0, IDLE.
//   dime+nickel then cancel -> REFUND 3 change_nickel pulses, no vend_req.
//   quarter during VEND and during REFUND -> coin_reject pulse each, credit
//     unchanged; cancel during VEND ignored.
//   reset_n low while vend_req=1 with credit 110 -> vend_req, credit 0 at once;
//     after release IDLE, next coin starts fresh.
//   VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8: one dime then idle -> REFUND after 8
//     cycles, 2 change_nickel pulses; a nickel on cycle 7 restarts the count.

Source files
------------

// File: rtl/vend_controller.sv
// Vending machine sequencing FSM: coin credit, dispense req/ack, nickel change/refund.
// Optional VEND_TIMEOUT_EN: auto-refund after TIMEOUT_CYCLES coin-free COLLECT cycles.
module vend_controller #(
  parameter int unsigned PRICE          = 100,
  parameter int unsigned CREDIT_W       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  input  logic                vend_ack,
  output logic                vend_req,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > 215) begin : g_bad_price
    $error("vend_controller: PRICE must be a multiple of 5 in 5..215");
  end
  if ((PRICE + 75) >= (1 << CREDIT_W)) begin : g_bad_width
    $error("vend_controller: CREDIT_W too narrow for PRICE-5+80");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("vend_controller: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);

  state_t              state;
  state_t              state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [5:0]          tally;
  logic [CREDIT_W-1:0] tally_w;
  logic                coin_in;
  logic                timeout;

  always_comb begin
    tally = '0;
    if (quarter) tally = tally + 6'd25;
    if (dime)    tally = tally + 6'd10;
    if (nickel)  tally = tally + 6'd5;
  end

  assign tally_w = CREDIT_W'(tally);
  assign coin_in = nickel | dime | quarter;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if (state != COLLECT || coin_in)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive coin-free COLLECT cycle.
  assign timeout = (state == COLLECT) && !coin_in &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      credit <= '0;
    end else begin
      state  <= state_next;
      credit <= credit_next;
    end
  end

  always_comb begin
    state_next  = state;
    credit_next = credit;
    case (state)
      IDLE: begin
        if (coin_in) begin
          state_next  = COLLECT;
          credit_next = tally_w;
        end
      end
      COLLECT: begin
        credit_next = credit + tally_w;
        if (cancel || timeout)
          state_next = REFUND;
        else if (credit >= PRICE_C)
          state_next = VEND;
      end
      VEND: begin
        if (vend_ack) begin
          credit_next = credit - PRICE_C;
          state_next  = (credit == PRICE_C) ? IDLE : REFUND;
        end
      end
      REFUND: begin
        credit_next = credit - NICKEL_C;
        if (credit == NICKEL_C)
          state_next = IDLE;
      end
      default: begin
        state_next  = IDLE;
        credit_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      coin_reject <= 1'b0;
    else
      coin_reject <= ((state == VEND) || (state == REFUND)) && coin_in;
  end

  always_comb begin
    vend_req      = (state == VEND);
    change_nickel = (state == REFUND);
    busy          = (state == VEND) || (state == REFUND);
  end

endmodule
